// File: rtl/ws2801_pkg.sv
// Shared types for the WS2801 receive path: pixel width, RGB layout and FSM states.
package ws2801_pkg;

    localparam int BITS_PER_PIXEL = 24;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RX,
        S_LATCH
    } rx_state_t;

endpackage

// File: rtl/ws2801_rx_sync.sv
// Brings the asynchronous WS2801 data/clock pins into the clk domain and
// flags each rising edge of the serial clock.
module ws2801_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sdi_in,
    input  logic sck_in,
    output logic sdi_s,
    output logic sck_s,
    output logic sck_rise
);

    logic [SYNC_STAGES-1:0] sdi_sync_q;
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic                   sck_hist_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sdi_sync_q <= '0;
            sck_sync_q <= '0;
            sck_hist_q <= 1'b0;
        end else begin
            sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi_in};
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck_in};
            sck_hist_q <= sck_sync_q[SYNC_STAGES-1];
        end
    end

    assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_hist_q;

endmodule

// File: rtl/ws2801_receiver.sv
// WS2801 stream receiver: rebuilds 24-bit pixels, strobes them out with their
// index and detects the idle-low latch. Define WS2801_RX_FRAMEBUF_EN for led_rgb.
module ws2801_receiver
    import ws2801_pkg::*;
#(
    parameter int LEDS         = 50,
    parameter int LATCH_CYCLES = 400,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sdi_in,
    input  logic                          sck_in,
    output logic [BITS_PER_PIXEL-1:0]     pixel_data,
    output logic [$clog2(LEDS)-1:0]       pixel_idx,
    output logic                          pixel_valid,
    output logic                          frame_done,
    output logic [$clog2(LEDS+1)-1:0]     frame_len,
    output logic                          err_overflow,
    output logic                          err_partial
`ifdef WS2801_RX_FRAMEBUF_EN
    ,
    output logic [BITS_PER_PIXEL*LEDS-1:0] led_rgb
`endif
);

    localparam int IW = $clog2(LEDS);
    localparam int CW = $clog2(LEDS+1);
    localparam int DW = $clog2(LATCH_CYCLES+1);
    localparam logic [CW-1:0] LEDS_C   = CW'(LEDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(LEDS-1);
    localparam logic [DW-1:0] LATCH_C  = DW'(LATCH_CYCLES);
    localparam logic [DW-1:0] LATCH_M1 = DW'(LATCH_CYCLES-1);

    logic sdi_s;
    logic sck_s;
    logic sck_rise;

    ws2801_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .sdi_in  (sdi_in),
        .sck_in  (sck_in),
        .sdi_s   (sdi_s),
        .sck_s   (sck_s),
        .sck_rise(sck_rise)
    );

    rx_state_t                 state_q;
    logic [BITS_PER_PIXEL-2:0] shift_q;
    logic [4:0]                bit_cnt_q;
    logic [CW-1:0]             pix_cnt_q;
    logic [DW-1:0]             idle_cnt_q;
    logic [DW-1:0]             idle_cnt_d;
    rgb_t                      pixel_q;
    logic [IW-1:0]             pixel_idx_q;
    logic                      pixel_valid_q;
    logic                      frame_done_q;
    logic [CW-1:0]             frame_len_q;
    logic                      err_overflow_q;
    logic                      err_partial_q;

    logic latch_hit;
    logic pix_done;
    logic room;
    rgb_t pixel_d;

    // Latch fires on the cycle the idle count reaches LATCH_CYCLES, which
    // requires sck low, so it can never collide with a rising edge.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (sck_s) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != LATCH_C) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
        latch_hit = (state_q == S_RX) && !sck_s && (idle_cnt_q == LATCH_M1);
        pix_done  = (state_q == S_RX) && sck_rise && (bit_cnt_q == 5'd23);
        room      = (pix_cnt_q != LEDS_C);
        pixel_d   = {shift_q, sdi_s};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            pix_cnt_q      <= '0;
            idle_cnt_q     <= '0;
            pixel_q        <= '0;
            pixel_idx_q    <= '0;
            pixel_valid_q  <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_len_q    <= '0;
            err_overflow_q <= 1'b0;
            err_partial_q  <= 1'b0;
        end else begin
            idle_cnt_q    <= idle_cnt_d;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (sck_rise) begin
                        shift_q   <= {shift_q[BITS_PER_PIXEL-3:0], sdi_s};
                        bit_cnt_q <= 5'd1;
                        state_q   <= S_RX;
                    end
                end
                S_RX: begin
                    if (latch_hit) begin
                        state_q      <= S_LATCH;
                        frame_done_q <= 1'b1;
                        frame_len_q  <= pix_cnt_q;
                        if (bit_cnt_q != 5'd0) begin
                            err_partial_q <= 1'b1;
                        end
                    end else if (sck_rise) begin
                        shift_q <= {shift_q[BITS_PER_PIXEL-3:0], sdi_s};
                        if (pix_done) begin
                            bit_cnt_q     <= 5'd0;
                            pixel_valid_q <= 1'b1;
                            pixel_q       <= pixel_d;
                            pixel_idx_q   <= room ? pix_cnt_q[IW-1:0] : LAST_IDX;
                            if (room) begin
                                pix_cnt_q <= pix_cnt_q + 1'b1;
                            end else begin
                                err_overflow_q <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                S_LATCH: begin
                    // An edge landing right after the latch opens the next frame.
                    pix_cnt_q <= '0;
                    if (sck_rise) begin
                        shift_q   <= {shift_q[BITS_PER_PIXEL-3:0], sdi_s};
                        bit_cnt_q <= 5'd1;
                        state_q   <= S_RX;
                    end else begin
                        bit_cnt_q <= 5'd0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign pixel_data   = pixel_q;
    assign pixel_idx    = pixel_idx_q;
    assign pixel_valid  = pixel_valid_q;
    assign frame_done   = frame_done_q;
    assign frame_len    = frame_len_q;
    assign err_overflow = err_overflow_q;
    assign err_partial  = err_partial_q;

`ifdef WS2801_RX_FRAMEBUF_EN
    logic [LEDS-1:0][BITS_PER_PIXEL-1:0] shadow_q;
    logic [LEDS-1:0][BITS_PER_PIXEL-1:0] led_q;

    // Shadow collects the frame; the visible copy moves only with frame_done.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow_q <= '0;
            led_q    <= '0;
        end else begin
            if (pix_done && room) begin
                shadow_q[pix_cnt_q[IW-1:0]] <= pixel_d;
            end
            if (latch_hit) begin
                led_q <= shadow_q;
            end
        end
    end

    assign led_rgb = led_q;
`endif

endmodule

// File: tb/tb_ws2801_receiver.sv
// Self-checking bench: two receivers (LEDS=3 and LEDS=2) share one WS2801
// stream; strobes are captured into queues and compared to hand-computed tables.
module tb_ws2801_receiver;

    localparam int LATCH = 400;

    logic clk;
    logic rst;
    logic sdi;
    logic sck;

    logic [23:0] aData;
    logic [1:0]  aIdx;
    logic        aValid;
    logic        aDone;
    logic [1:0]  aLen;
    logic        aOvf;
    logic        aPart;
    logic [23:0] bData;
    logic [0:0]  bIdx;
    logic        bValid;
    logic        bDone;
    logic [1:0]  bLen;
    logic        bOvf;
    logic        bPart;
`ifdef WS2801_RX_FRAMEBUF_EN
    logic [71:0] aLed;
    logic [47:0] bLed;
`endif

    int checks = 0;
    int errors = 0;

    logic [23:0] aDataQ[$];
    logic [1:0]  aIdxQ[$];
    logic [1:0]  aLenQ[$];
    logic [23:0] bDataQ[$];
    logic [0:0]  bIdxQ[$];
    logic [1:0]  bLenQ[$];

    typedef struct {
        logic [23:0] word;
        logic [1:0]  expIdxA;
        logic [0:0]  expIdxB;
    } vec_t;

    vec_t frame1[3];
    vec_t frame2[3];

    ws2801_receiver #(.LEDS(3), .LATCH_CYCLES(LATCH), .SYNC_STAGES(2)) dutA (
        .clk         (clk),
        .rst         (rst),
        .sdi_in      (sdi),
        .sck_in      (sck),
        .pixel_data  (aData),
        .pixel_idx   (aIdx),
        .pixel_valid (aValid),
        .frame_done  (aDone),
        .frame_len   (aLen),
        .err_overflow(aOvf),
        .err_partial (aPart)
`ifdef WS2801_RX_FRAMEBUF_EN
        ,
        .led_rgb     (aLed)
`endif
    );

    ws2801_receiver #(.LEDS(2), .LATCH_CYCLES(LATCH), .SYNC_STAGES(2)) dutB (
        .clk         (clk),
        .rst         (rst),
        .sdi_in      (sdi),
        .sck_in      (sck),
        .pixel_data  (bData),
        .pixel_idx   (bIdx),
        .pixel_valid (bValid),
        .frame_done  (bDone),
        .frame_len   (bLen),
        .err_overflow(bOvf),
        .err_partial (bPart)
`ifdef WS2801_RX_FRAMEBUF_EN
        ,
        .led_rgb     (bLed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every strobe on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (aValid) begin
            aDataQ.push_back(aData);
            aIdxQ.push_back(aIdx);
        end
        if (aDone) aLenQ.push_back(aLen);
        if (bValid) begin
            bDataQ.push_back(bData);
            bIdxQ.push_back(bIdx);
        end
        if (bDone) bLenQ.push_back(bLen);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends the top nbits of word MSB first, 8 clk low then 8 clk high per bit.
    task automatic applyStimulus(input logic [23:0] word, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            sdi = word[23-i];
            tick(8);
            sck = 1'b1;
            tick(8);
            sck = 1'b0;
        end
    endtask

    task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clearQueues();
        aDataQ.delete(); aIdxQ.delete(); aLenQ.delete();
        bDataQ.delete(); bIdxQ.delete(); bLenQ.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_a_data"},  96'(aData),  96'(0));
        checkOutput({tag, "_a_idx"},   96'(aIdx),   96'(0));
        checkOutput({tag, "_a_valid"}, 96'(aValid), 96'(0));
        checkOutput({tag, "_a_done"},  96'(aDone),  96'(0));
        checkOutput({tag, "_a_len"},   96'(aLen),   96'(0));
        checkOutput({tag, "_a_ovf"},   96'(aOvf),   96'(0));
        checkOutput({tag, "_a_part"},  96'(aPart),  96'(0));
        checkOutput({tag, "_b_data"},  96'(bData),  96'(0));
        checkOutput({tag, "_b_ovf"},   96'(bOvf),   96'(0));
`ifdef WS2801_RX_FRAMEBUF_EN
        checkOutput({tag, "_a_led"},   96'(aLed),   96'(0));
        checkOutput({tag, "_b_led"},   96'(bLed),   96'(0));
`endif
    endtask

    initial begin
        frame1[0] = '{24'hFF0000, 2'd0, 1'd0};
        frame1[1] = '{24'h00FF00, 2'd1, 1'd1};
        frame1[2] = '{24'h0000FF, 2'd2, 1'd1};
        frame2[0] = '{24'h010203, 2'd0, 1'd0};
        frame2[1] = '{24'h405060, 2'd1, 1'd1};
        frame2[2] = '{24'h7F8091, 2'd2, 1'd1};

        rst = 1'b0;
        sdi = 1'b0;
        sck = 1'b0;
        tick(4);
        checkAllZero("reset");
        rst = 1'b1;
        tick(2);

        $display("[TB] full frame of three pixels");
        clearQueues();
        for (int i = 0; i < 3; i++) applyStimulus(frame1[i].word, 24);
        tick(LATCH + 20);
        checkOutput("f1_a_npix", 96'(aDataQ.size()), 96'(3));
        checkOutput("f1_b_npix", 96'(bDataQ.size()), 96'(3));
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("f1_a_data%0d", i), 96'(aDataQ[i]), 96'(frame1[i].word));
            checkOutput($sformatf("f1_a_idx%0d", i),  96'(aIdxQ[i]),  96'(frame1[i].expIdxA));
            checkOutput($sformatf("f1_b_idx%0d", i),  96'(bIdxQ[i]),  96'(frame1[i].expIdxB));
        end
        checkOutput("f1_a_nframes", 96'(aLenQ.size()), 96'(1));
        checkOutput("f1_a_len",     96'(aLenQ[0]),     96'(3));
        checkOutput("f1_b_len",     96'(bLenQ[0]),     96'(2));
        checkOutput("f1_a_ovf",     96'(aOvf),         96'(0));
        checkOutput("f1_a_part",    96'(aPart),        96'(0));
        checkOutput("f1_b_ovf",     96'(bOvf),         96'(1));
        checkOutput("f1_b_part",    96'(bPart),        96'(0));
`ifdef WS2801_RX_FRAMEBUF_EN
        checkOutput("f1_a_led", 96'(aLed), 96'(72'h0000FF_00FF00_FF0000));
        checkOutput("f1_b_led", 96'(bLed), 96'(48'h00FF00_FF0000));
`endif

        $display("[TB] 30-bit partial frame");
        clearQueues();
        applyStimulus(24'hA5C3E7, 24);
        applyStimulus(24'hFC0000, 6);
        tick(LATCH + 20);
        checkOutput("p_a_npix",    96'(aDataQ.size()), 96'(1));
        checkOutput("p_a_data",    96'(aDataQ[0]),     96'(24'hA5C3E7));
        checkOutput("p_a_idx",     96'(aIdxQ[0]),      96'(0));
        checkOutput("p_a_nframes", 96'(aLenQ.size()),  96'(1));
        checkOutput("p_a_len",     96'(aLenQ[0]),      96'(1));
        checkOutput("p_a_part",    96'(aPart),         96'(1));
        checkOutput("p_b_part",    96'(bPart),         96'(1));
`ifdef WS2801_RX_FRAMEBUF_EN
        checkOutput("p_a_led", 96'(aLed), 96'(72'h0000FF_00FF00_A5C3E7));
        checkOutput("p_b_led", 96'(bLed), 96'(48'h00FF00_A5C3E7));
`endif

        clearQueues();
        for (int i = 0; i < 3; i++) applyStimulus(frame2[i].word, 24);
        tick(LATCH + 20);
        checkOutput("f2_a_npix", 96'(aDataQ.size()), 96'(3));
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("f2_a_data%0d", i), 96'(aDataQ[i]), 96'(frame2[i].word));
            checkOutput($sformatf("f2_a_idx%0d", i),  96'(aIdxQ[i]),  96'(frame2[i].expIdxA));
        end
        checkOutput("f2_a_len", 96'(aLenQ[0]), 96'(3));
        checkOutput("f2_a_ovf", 96'(aOvf),     96'(0));

        $display("[TB] reset after 12 bits");
        clearQueues();
        applyStimulus(24'hABC000, 12);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        checkAllZero("midrst");
        tick(LATCH + 20);
        checkOutput("midrst_a_nframes", 96'(aLenQ.size()),  96'(0));
        checkOutput("midrst_b_nframes", 96'(bLenQ.size()),  96'(0));
        checkOutput("midrst_a_npix",    96'(aDataQ.size()), 96'(0));
        applyStimulus(24'h123456, 24);
        tick(LATCH + 20);
        checkOutput("clean_a_data", 96'(aDataQ[0]), 96'(24'h123456));
        checkOutput("clean_a_idx",  96'(aIdxQ[0]),  96'(0));
        checkOutput("clean_a_len",  96'(aLenQ[0]),  96'(1));
        checkOutput("clean_a_part", 96'(aPart),     96'(0));
        checkOutput("clean_b_ovf",  96'(bOvf),      96'(0));
`ifdef WS2801_RX_FRAMEBUF_EN
        checkOutput("clean_a_led", 96'(aLed), 96'(72'h000000_000000_123456));
`endif

        // applyStimulus adds 8 low clk before each bit, hence the -9 / -8.
        $display("[TB] inter-pixel gap of LATCH-1");
        clearQueues();
        applyStimulus(24'h111111, 24);
        tick(LATCH - 9);
        applyStimulus(24'h222222, 24);
        tick(LATCH + 20);
        checkOutput("gap1_a_npix",    96'(aDataQ.size()), 96'(2));
        checkOutput("gap1_a_idx1",    96'(aIdxQ[1]),      96'(1));
        checkOutput("gap1_a_data1",   96'(aDataQ[1]),     96'(24'h222222));
        checkOutput("gap1_a_nframes", 96'(aLenQ.size()),  96'(1));
        checkOutput("gap1_a_len",     96'(aLenQ[0]),      96'(2));

        $display("[TB] inter-pixel gap of LATCH");
        clearQueues();
        applyStimulus(24'h333333, 24);
        tick(LATCH - 8);
        applyStimulus(24'h444444, 24);
        tick(LATCH + 20);
        checkOutput("gap2_a_nframes", 96'(aLenQ.size()),  96'(2));
        checkOutput("gap2_a_len0",    96'(aLenQ[0]),      96'(1));
        checkOutput("gap2_a_len1",    96'(aLenQ[1]),      96'(1));
        checkOutput("gap2_a_npix",    96'(aDataQ.size()), 96'(2));
        checkOutput("gap2_a_idx1",    96'(aIdxQ[1]),      96'(0));
        checkOutput("gap2_a_data1",   96'(aDataQ[1]),     96'(24'h444444));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ws2801_receiver.md
Name: ws2801_receiver

Overview:
- Receive-side counterpart of the WS2801 LED driver: samples the two-wire WS2801 stream (serial data + serial clock) in the system clock domain.
- Rebuilds 24-bit pixels, streams each pixel out with its index, and detects the end-of-frame latch (serial clock idle low).
- Two uses: loopback self-check of the driver on the DE1-SoC (GPIO in → out), and a bench/on-board strip model.

Parameters:
- LEDS, 50, pixels per frame; sizes the index and the frame buffer.
- LATCH_CYCLES, 400, consecutive clk cycles with sck_in low that define a latch/frame end (≥ 500 µs at the strip's clock is not required; LATCH_CYCLES is a pure clk count).
- SYNC_STAGES, 2, synchronizer depth on sdi_in/sck_in (minimum 2).

Ports:
- clk  input  1  system clock; must be ≥ 8× the sck_in frequency.
- rst  input  1  synchronous, active-low reset.
- sdi_in  input  1  WS2801 serial data (asynchronous).
- sck_in  input  1  WS2801 serial clock (asynchronous).
- pixel_data  output  24  last completed pixel, {R,G,B}; each byte MSB first on the wire.
- pixel_idx  output  $clog2(LEDS)  index of pixel_data in the frame (first pixel = 0).
- pixel_valid  output  1  one-cycle strobe: pixel_data/pixel_idx are new.
- frame_done  output  1  one-cycle strobe on latch detection.
- frame_len  output  $clog2(LEDS+1)  pixels received in the frame just ended; valid while frame_done is high, held afterwards.
- err_overflow  output  1  sticky; more than LEDS pixels received in a frame.
- err_partial  output  1  sticky; latch arrived with 1–23 bits pending.
- led_rgb  output  24*LEDS  frame buffer; present only with WS2801_RX_FRAMEBUF_EN.

Behaviour:
- Reset (rst == 0 at posedge clk):
  - All outputs are 0; FSM goes to S_IDLE.
  - Bit, pixel and idle counters clear. The synchronizer is loaded with 0.
  - Reset mid-frame discards the partial pixel and the frame; no frame_done is generated.
- Input path:
  - SYNC_STAGES flops per input, then one history flop on sck.
  - A rising edge is sck_s == 1 and sck_q == 0.
  - sdi is sampled from its synchronized value in the same cycle the edge is detected.
  - Pin-to-shift latency is SYNC_STAGES+1 clk.
- Shift: shift_reg <= {shift_reg[22:0], sdi_s} on each rising edge; bit_cnt 0..23.
- Pixel complete (rising edge with bit_cnt == 23):
  - Next cycle: pixel_valid = 1 and pixel_data = completed word. pixel_idx = pix_cnt, which then increments.
  - bit_cnt wraps to 0.
- Overflow: when pix_cnt == LEDS, further pixels still pulse pixel_valid, pixel_idx saturates at LEDS-1, and err_overflow is set. Extra pixels are not written to led_rgb.
- Idle counter:
  - Clears on any cycle with sck_s == 1; otherwise increments, saturating at LATCH_CYCLES.
  - Reaching LATCH_CYCLES in S_RX triggers the latch.
- FSM:
  - S_IDLE: waits for the first rising edge → S_RX, and that edge shifts its bit. Idle timeouts here produce nothing.
  - S_RX: shifts bits. On latch → S_LATCH.
  - S_LATCH: one cycle.
    - frame_done = 1 and frame_len = min(pix_cnt, LEDS).
    - If bit_cnt != 0, err_partial is set.
    - bit_cnt and pix_cnt clear, the partial pixel is discarded, then → S_IDLE.
- Simultaneous events:
  - A rising edge cannot coincide with latch, because the idle counter is cleared by sck high.
  - pixel_valid and frame_done never coincide: the pixel strobe precedes S_LATCH by at least LATCH_CYCLES.
- Error flags clear only on reset.
- A zero-length frame is impossible: S_IDLE ignores idle.

Optional Feature:
- WS2801_RX_FRAMEBUF_EN defined:
  - led_rgb is a port plus 24*LEDS registers.
  - Each valid pixel k < LEDS is written to a shadow buffer at bits [24k+23:24k].
  - Shadow is copied to led_rgb in the S_LATCH cycle, so led_rgb changes only together with frame_done.
  - Pixels not received in a short frame keep their previous value. Reset clears both buffers.
  - The layout matches the driver's led_rgb, so loopback compares directly.
- Not defined: no led_rgb port, no buffer registers; streaming outputs only.

Decomposition:
- Package ws2801_pkg holds:
  - BITS_PER_PIXEL = 24.
  - The rgb_t typedef (packed struct r, g, b, 8 bits each).
  - The rx_state_t enum {S_IDLE, S_RX, S_LATCH}.
- One sub-module, ws2801_rx_sync: SYNC_STAGES synchronizer for both inputs plus sck rising-edge detect. Outputs sdi_s and sck_rise.

Test Plan:
- One frame, LEDS=3, pixels 0xFF0000, 0x00FF00, 0x0000FF, sck period 16 clk, then sck low 400 clk → three pixel_valid strobes with idx 0,1,2 and matching data. frame_done once, frame_len = 3, no errors.
- 30 bits then latch → one pixel_valid; frame_done with frame_len = 1; err_partial = 1. Next full frame starts at idx 0 with the correct data.
- LEDS=2, send 3 pixels → third pixel_valid with idx 1; err_overflow = 1; frame_len = 2. With WS2801_RX_FRAMEBUF_EN, led_rgb holds only the first two.
- rst low for 1 clk after 12 bits of a pixel → all outputs 0, no frame_done. Subsequent clean frame 0x123456 → pixel_data = 0x123456 at idx 0.
- Gap of LATCH_CYCLES-1 low clk between pixels 0 and 1 → no frame_done, idx continues to 1. Gap of LATCH_CYCLES → frame_done after pixel 0.
- Loopback: LED driver (LEDS=50, COMPLEXITY=2) drives the receiver with WS2801_RX_FRAMEBUF_EN defined → on each frame_done, led_rgb equals the driver's led_rgb.
